// File: rtl/uart_tx_word_fifo.sv
// Word buffer between the parser result path and the 4-byte UART transmitter; overflow drops and counts.
// Optional: define TX_SYNC_HEADER_EN to insert SYNC_WORD ahead of every HDR_PERIOD data words.
module uart_tx_word_fifo #(
  parameter int          DEPTH      = 16,
  parameter logic [31:0] SYNC_WORD  = 32'hA5A5_5A5A,
  parameter int          HDR_PERIOD = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [31:0]                 out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH+2)-1:0]  level,
  output logic [15:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(DEPTH + 2);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HDR_PERIOD < 1 || $bits(SYNC_WORD) != 32)
  begin : g_bad_cfg
    $error("uart_tx_word_fifo: DEPTH must be a power of 2 >= 2 and HDR_PERIOD >= 1");
  end

`ifdef TX_SYNC_HEADER_EN
  typedef enum logic [1:0] {ST_EMPTY, ST_LOADED, ST_HDR} state_t;
`else
  typedef enum logic [1:0] {ST_EMPTY, ST_LOADED} state_t;
`endif

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [LW-1:0] r_level;
  logic [15:0]   r_drop_cnt;
  logic [31:0]   r_out_data;
  logic          r_out_valid;
  state_t        r_state;

  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic          w_xfer;
  logic          w_need;
  logic          w_avail;
  logic          w_load_data;
  logic          w_load_hdr;
  logic          w_valid_next;
  logic [CW-1:0] w_count_next;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = in_valid && !w_full;
  assign w_drop  = in_valid && w_full;
  assign w_xfer  = r_out_valid && out_ready;
  // Output register is free to take a new word this cycle (empty, or being emptied).
  assign w_need  = (r_state == ST_EMPTY) || w_xfer;
  assign w_avail = (r_count != '0);

`ifdef TX_SYNC_HEADER_EN
  localparam int HW = (HDR_PERIOD > 1) ? $clog2(HDR_PERIOD) : 1;

  logic [HW-1:0] r_hdr_cnt;
  logic          r_hdr_due;
  logic          w_data_xfer;
  logic          w_period_end;
  logic          w_due_now;

  assign w_data_xfer  = w_xfer && (r_state == ST_LOADED);
  assign w_period_end = w_data_xfer && (r_hdr_cnt == HW'(HDR_PERIOD - 1));
  assign w_due_now    = r_hdr_due || w_period_end;
  // A header is only launched when a data word is waiting behind it.
  assign w_load_hdr   = w_need && w_avail && w_due_now && (r_state != ST_HDR);
  assign w_load_data  = w_need && w_avail && !w_load_hdr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_cnt <= '0;
      r_hdr_due <= 1'b1;
    end else begin
      if (w_period_end)     r_hdr_cnt <= '0;
      else if (w_data_xfer) r_hdr_cnt <= r_hdr_cnt + 1'b1;
      r_hdr_due <= (r_state == ST_HDR && w_xfer) ? 1'b0 : w_due_now;
    end
  end
`else
  assign w_load_hdr  = 1'b0;
  assign w_load_data = w_need && w_avail;
`endif

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_load_data})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_valid_next = r_out_valid;
    if (w_load_data || w_load_hdr) w_valid_next = 1'b1;
    else if (w_xfer)               w_valid_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_level     <= '0;
      r_drop_cnt  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_state     <= ST_EMPTY;
    end else begin
      if (w_push)      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load_data) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
      r_count     <= w_count_next;
      // Level is registered from next-state values so it never glitches.
      r_level     <= LW'(w_count_next) + LW'(w_valid_next);
      r_out_valid <= w_valid_next;
`ifdef TX_SYNC_HEADER_EN
      if (w_load_hdr) begin
        r_out_data <= SYNC_WORD;
        r_state    <= ST_HDR;
      end else
`endif
      if (w_load_data) begin
        r_out_data <= r_mem[r_rd_ptr];
        r_state    <= ST_LOADED;
      end else if (w_xfer) begin
        r_state    <= ST_EMPTY;
      end
    end
  end

  assign in_ready  = !w_full;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign level     = r_level;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_uart_tx_word_fifo.sv
// Directed bench for uart_tx_word_fifo: latency, stall, overflow, wrap with UART-paced sink, async reset,
// and the sync header sequence when TX_SYNC_HEADER_EN is defined.
module tb_uart_tx_word_fifo;

  localparam int          DEPTH = 16;
  localparam logic [31:0] SYNC  = 32'hA5A5_5A5A;
  localparam int          HDR_P = 2;

  // Handshake: a word moves on every rising edge where out_valid && out_ready;
  // the bench changes inputs 1 time unit after the edge and samples on the falling edge.
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic [15:0] drop_cnt;

  logic        rdy_cmd = 1'b0;
  logic        uart_mode = 1'b0;
  logic        uart_rdy = 1'b1;
  int          uart_busy = 0;
  logic        mon_hs = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          rx_cnt = 0;
  int          n_data = 0;
  int          max_level = 0;
  int          r0;

  assign out_ready = uart_mode ? uart_rdy : rdy_cmd;

  uart_tx_word_fifo #(.DEPTH(DEPTH), .SYNC_WORD(SYNC), .HDR_PERIOD(HDR_P)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .drop_cnt(drop_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic sb_add(input logic [31:0] w);
`ifdef TX_SYNC_HEADER_EN
    if (n_data % HDR_P == 0) exp_q.push_back(SYNC);
`endif
    exp_q.push_back(w);
    n_data++;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(level) > max_level) max_level = int'(level);
      mon_hs = out_valid && out_ready;
      if (out_valid && out_ready) begin
        rx_cnt++;
        check("xfer_queue", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("xfer_data", out_data, exp_q.pop_front());
      end
    end
  end

  // UART-like sink: ready drops after each accept and returns 44 cycles later.
  always @(posedge clk) begin
    #1;
    if (!uart_mode) begin
      uart_busy = 0;
      uart_rdy  = 1'b1;
    end else if (mon_hs) begin
      uart_busy = 43;
      uart_rdy  = 1'b0;
    end else if (uart_busy > 0) begin
      uart_busy--;
      uart_rdy = (uart_busy == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input bit accepted);
    in_data  = w;
    in_valid = 1'b1;
    if (accepted) sb_add(w);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    rdy_cmd = 1'b0;
    uart_mode = 1'b0;
    exp_q.delete();
    n_data = 0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      idle(1);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Pointer wrap: four bursts of 10 words, UART-paced sink.
    uart_mode = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) push_word(32'hC000_0000 + 32'(b * 10 + i), 1'b1);
      idle(700);
    end
    wait_drain("t4_drain", 3000);
    check("t4_drop_cnt", 32'(drop_cnt), 32'd0);
    check("t4_max_level_ok", 32'(max_level <= DEPTH + 1), 32'd1);
    uart_mode = 1'b0;
    rdy_cmd = 1'b0;
    idle(2);

`ifndef TX_SYNC_HEADER_EN
    // Single word latency with sink always ready.
    rdy_cmd = 1'b1;
    push_word(32'h1234_5678, 1'b1);
    check("t1_valid_n1", 32'(out_valid), 32'd0);
    check("t1_level_n1", 32'(level),     32'd1);
    idle(1);
    check("t1_valid_n2", 32'(out_valid), 32'd1);
    check("t1_data_n2",  out_data,       32'h1234_5678);
    check("t1_level_n2", 32'(level),     32'd1);
    idle(1);
    check("t1_valid_n3", 32'(out_valid), 32'd0);
    check("t1_level_n3", 32'(level),     32'd0);
    check("t1_queue",    32'(exp_q.size()), 32'd0);

    // Stalled sink, five words, then release.
    rdy_cmd = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(32'(i), 1'b1);
    idle(2);
    check("t2_level",  32'(level),     32'd5);
    check("t2_valid",  32'(out_valid), 32'd1);
    check("t2_data",   out_data,       32'd1);
    idle(3);
    check("t2_hold",   out_data,       32'd1);
    rdy_cmd = 1'b1;
    r0 = rx_cnt;
    idle(5);
    check("t2_rate",   32'(rx_cnt - r0), 32'd5);
    check("t2_level0", 32'(level),     32'd0);
    check("t2_valid0", 32'(out_valid), 32'd0);

    // Overflow: 20 words into 16 entries + output register.
    rdy_cmd = 1'b0;
    for (int i = 1; i <= 20; i++) push_word(32'h300 + 32'(i), i <= 17);
    idle(2);
    check("t3_level",    32'(level),    32'd17);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd3);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    check("t3_head",     out_data,      32'h301);
    rdy_cmd = 1'b1;
    wait_drain("t3_drain", 100);
    idle(2);
    check("t3_level0",   32'(level),    32'd0);
    check("t3_in_ready1", 32'(in_ready), 32'd1);
    check("t3_drop_hold", 32'(drop_cnt), 32'd3);

    // Async reset while loaded with level 6.
    rdy_cmd = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'h500 + 32'(i), 1'b1);
    idle(2);
    check("t5_level6", 32'(level),     32'd6);
    check("t5_valid",  32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_level", 32'(level),     32'd0);
    check("t5_rst_drop",  32'(drop_cnt),  32'd0);
    check("t5_rst_data",  out_data,       32'd0);
    check("t5_rst_ready", 32'(in_ready),  32'd1);
    exp_q.delete();
    n_data = 0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    rdy_cmd = 1'b1;
    push_word(32'h1234_5678, 1'b1);
    check("t5_valid_n1", 32'(out_valid), 32'd0);
    idle(1);
    check("t5_valid_n2", 32'(out_valid), 32'd1);
    check("t5_data_n2",  out_data,       32'h1234_5678);
    idle(1);
    check("t5_valid_n3", 32'(out_valid), 32'd0);
    check("t5_level_n3", 32'(level),     32'd0);
`else
    // Header sequence with HDR_PERIOD=2: H A B H C D, nothing after.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'hA + 32'(i), 1'b1);
    idle(1);
    check("th_level", 32'(level),     32'd5);
    check("th_valid", 32'(out_valid), 32'd1);
    check("th_head",  out_data,       SYNC);
    rdy_cmd = 1'b1;
    r0 = rx_cnt;
    idle(6);
    check("th_count", 32'(rx_cnt - r0), 32'd6);
    idle(5);
    check("th_idle_valid", 32'(out_valid), 32'd0);
    check("th_idle_level", 32'(level),     32'd0);
    check("th_queue",      32'(exp_q.size()), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_word_fifo.md
Name: uart_tx_word_fifo

Overview:
Buffers 32-bit result words from the parser/result path and presents them one at a time to the 4-byte UART transmitter. The parser cannot stall, so words that arrive while the buffer is full are dropped and counted. The output uses a registered valid/ready handshake: out_valid drives the transmitter's data_valid, out_ready is driven by the transmitter's ready, and out_data drives its data_in.

Parameters:
DEPTH, 16, memory entries; power of 2, >=2
SYNC_WORD, 32'hA5A5_5A5A, header word; used only with TX_SYNC_HEADER_EN
HDR_PERIOD, 8, data words between headers; >=1; used only with TX_SYNC_HEADER_EN

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_data  in  32  word from the parser
in_valid  in  1  one-cycle strobe; in_data is valid this cycle
in_ready  out  1  high when the memory is not full; informational, the source may ignore it
out_data  out  32  word presented to the transmitter
out_valid  out  1  out_data holds a word awaiting transfer
out_ready  in  1  sink can accept; transfer occurs in any cycle where out_valid && out_ready
level  out  $clog2(DEPTH+2)  memory entries + 1 if out_valid
drop_cnt  out  16  saturating count of dropped words

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: out_valid=0, out_data=0, drop_cnt=0, level=0, in_ready=1.
  - Internal: pointers and count cleared; header counter cleared.
  - Reset mid-transfer discards all content; no partial state survives.
- Storage:
  - DEPTH-entry circular memory with wr_ptr/rd_ptr of $clog2(DEPTH) bits; pointers wrap naturally from DEPTH-1 to 0.
  - Separate count register, 0..DEPTH.
- Push:
  - Occurs when in_valid && count<DEPTH, evaluated on the registered count.
  - When in_valid && count==DEPTH: the word is dropped and drop_cnt increments, saturating at 16'hFFFF.
  - A pop in the same cycle does not rescue a push while full; the push is still dropped.
- in_ready = (count != DEPTH), combinational from registers.
- Output register states:
  - EMPTY: out_valid=0.
  - LOADED: out_valid=1.
- Transitions:
  - EMPTY with count>0 → load mem[rd_ptr] into out_data, rd_ptr++, count--, go LOADED.
  - LOADED with out_ready → transfer. If count>0, reload the next word in the same cycle and stay LOADED; otherwise go EMPTY and set out_valid=0 next cycle.
  - LOADED with !out_ready → out_data and out_valid held stable.
- Simultaneous push and reload in one cycle: count is unchanged. A word written into an empty memory is not readable until the following cycle.
- Latency: in_valid at cycle N into an empty block → out_valid=1 at N+2 (write at N, load at N+1, registered output at N+2).
- Throughput: one word per cycle when the sink is always ready. With the UART transmitter, ready drops the cycle after accept, so no word is double-accepted.
- level = count + out_valid, registered-equivalent and glitch-free; maximum value DEPTH+1.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

Optional Feature:
TX_SYNC_HEADER_EN
- Defined:
  - The output stage gains a third state, HDR.
  - Header placement: SYNC_WORD is presented before the first data word after reset, and before the next data word after every HDR_PERIOD transferred data words.
  - A header is emitted only when a data word is available (count>0). It never appears alone on an idle line.
  - The header does not consume memory.
  - The header counts in level while presented.
  - The header uses the same out_valid/out_ready handshake.
  - A header transfer does not advance the data-word counter.
- Undefined: no HDR state and no header counter; SYNC_WORD and HDR_PERIOD are ignored; behaviour is exactly as above.

Test Plan:
- Reset then single push of 32'h1234_5678 at cycle N, out_ready=1 → out_valid at N+2, out_data=32'h1234_5678, one transfer, then out_valid=0, level=0.
- Push 5 words 1..5 back-to-back with out_ready=0 → level=5, out_data=1 stable; release out_ready → words 1..5 transferred in order, one per cycle.
- DEPTH=16, out_ready=0, push 20 words → 17 held (16 memory + output register); pushes 18-20 dropped, so drop_cnt=3 and in_ready=0; drain all → received 1..17 in order.
- Pointer wrap: 40 words pushed with out_ready toggled by the UART-like sink (one accept per 44 cycles) → no loss or reorder, and level never exceeds DEPTH+1.
- Async reset asserted while LOADED with level=6 → out_valid=0, level=0 and drop_cnt=0 immediately; next push after release behaves as in the first scenario.
- With TX_SYNC_HEADER_EN, HDR_PERIOD=2, push 4 words A,B,C,D → sequence A5A55A5A, A, B, A5A55A5A, C, D; no trailing header with the memory empty.
